// File: rtl/op_tile_writer.sv
// rtl/op_tile_writer.sv - output tile write-address generator with a single-slot write register
// Optional feature: define OUT_RELU_EN to clamp negative pixels to zero on capture.
module op_tile_writer #(
   parameter int DATA_WIDTH = 15,
   parameter int ADDR_WIDTH = 31,
   parameter int PIX_WIDTH  = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH:0]   H,
   input  logic [DATA_WIDTH:0]   W,
   input  logic [DATA_WIDTH:0]   C,
   input  logic [DATA_WIDTH:0]   Th,
   input  logic [DATA_WIDTH:0]   Tw,
   input  logic [DATA_WIDTH:0]   ho,
   input  logic [DATA_WIDTH:0]   wo,
   input  logic                  in_valid,
   input  logic [PIX_WIDTH:0]    in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH:0]   wr_addr,
   output logic [PIX_WIDTH:0]    wr_data,
   input  logic                  wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           beat_cnt
);

   localparam int GW  = DATA_WIDTH + 1;
   localparam int PW0 = 3 * GW + 2;
   localparam int PW  = (PW0 > ADDR_WIDTH + 1) ? PW0 : ADDR_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
   state_t state;

   logic [DATA_WIDTH:0]   w_r, c_r, wo_r, c_last;
   logic [DATA_WIDTH+1:0] h_last, w_last;
   logic [DATA_WIDTH:0]   h_idx, w_idx, c_idx;

   logic [DATA_WIDTH:0]   h_room, w_room, eh, ew;
   logic                  empty_tile;
   logic [PW-1:0]         addr_full;
   logic [PIX_WIDTH:0]    pix_out;
   logic                  beat, accept, c_end, w_end, h_end;

   assign in_ready = (state == S_RUN) && (!wr_en || wr_ready);
   assign beat     = in_valid && in_ready;
   assign accept   = wr_en && wr_ready;

   // Room values only matter when the tile is non-empty, so their wrap is harmless.
   always_comb begin
      h_room     = H - ho;
      w_room     = W - wo;
      eh         = (Th < h_room) ? Th : h_room;
      ew         = (Tw < w_room) ? Tw : w_room;
      empty_tile = (C == '0) || (Th == '0) || (Tw == '0) || (ho >= H) || (wo >= W);
   end

   always_comb begin
      addr_full = (PW'(h_idx) * PW'(w_r) + PW'(w_idx)) * PW'(c_r) + PW'(c_idx);
      c_end     = (c_idx == c_last);
      w_end     = ({1'b0, w_idx} == w_last);
      h_end     = ({1'b0, h_idx} == h_last);
   end

`ifdef OUT_RELU_EN
   always_comb pix_out = in_data[PIX_WIDTH] ? '0 : in_data;
`else
   always_comb pix_out = in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         beat_cnt <= '0;
         w_r      <= '0;
         c_r      <= '0;
         wo_r     <= '0;
         c_last   <= '0;
         h_last   <= '0;
         w_last   <= '0;
         h_idx    <= '0;
         w_idx    <= '0;
         c_idx    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  w_r      <= W;
                  c_r      <= C;
                  wo_r     <= wo;
                  c_last   <= C - GW'(1);
                  h_last   <= {1'b0, ho} + {1'b0, eh} - (GW+1)'(1);
                  w_last   <= {1'b0, wo} + {1'b0, ew} - (GW+1)'(1);
                  beat_cnt <= '0;
                  h_idx    <= ho;
                  w_idx    <= wo;
                  c_idx    <= '0;
                  if (empty_tile) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            S_RUN, S_FLUSH: begin
               if (accept)
                  beat_cnt <= beat_cnt + 32'd1;
               if (beat) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr_full[ADDR_WIDTH:0];
                  wr_data <= pix_out;
                  if (c_end) begin
                     c_idx <= '0;
                     if (w_end) begin
                        w_idx <= wo_r;
                        h_idx <= h_idx + GW'(1);
                     end else begin
                        w_idx <= w_idx + GW'(1);
                     end
                  end else begin
                     c_idx <= c_idx + GW'(1);
                  end
                  if (c_end && w_end && h_end)
                     state <= S_FLUSH;
               end else if (accept) begin
                  wr_en <= 1'b0;
               end
               // in_ready is low in FLUSH, so an accept there is always the final write.
               if (state == S_FLUSH && accept) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_op_tile_writer.sv
// tb/tb_op_tile_writer.sv - randomized self-checking bench for op_tile_writer
// Expected write sequences come from nested-loop address arithmetic over the tile.
module tb_op_tile_writer;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, wr_ready;
   logic [15:0] H, W, C, Th, Tw, ho, wo, in_data;
   logic        in_ready, wr_en, busy, done;
   logic [31:0] wr_addr, beat_cnt;
   logic [15:0] wr_data;

   always #5 clk = ~clk;

   op_tile_writer dut (
      .clk(clk), .rst(rst), .start(start),
      .H(H), .W(W), .C(C), .Th(Th), .Tw(Tw), .ho(ho), .wo(wo),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done), .beat_cnt(beat_cnt)
   );

   int cmp_n = 0;
   int err_n = 0;

   logic [31:0] exp_addr[$];
   logic [15:0] pix_q[$];
   logic [15:0] pix_ref[$];
   logic [31:0] obs_addr[$];
   logic [15:0] obs_data[$];
   int done_cnt, done_cyc, first_acc_cyc, last_acc_cyc, busy_hi, wr_seen;
   int bp_viol, extra_done, extra_rdy, stall_at, stall_len, stall_cnt;
   logic [31:0] bp_addr;
   bit timed_out;

   function automatic logic [15:0] relu_ref(input logic [15:0] v);
`ifdef OUT_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // Reference: walk the clipped tile row by row, column by column, channel innermost.
   task automatic model_tile(input int gh, gw, gc, gth, gtw, gho, gwo);
      int eh, ew;
      longint a;
      exp_addr.delete();
      if (gc == 0 || gth == 0 || gtw == 0 || gho >= gh || gwo >= gw) return;
      eh = (gth < gh - gho) ? gth : gh - gho;
      ew = (gtw < gw - gwo) ? gtw : gw - gwo;
      for (int hh = gho; hh < gho + eh; hh++)
         for (int ww = gwo; ww < gwo + ew; ww++)
            for (int cc = 0; cc < gc; cc++) begin
               a = (longint'(hh) * gw + ww) * gc + cc;
               exp_addr.push_back(a[31:0]);
            end
   endtask

   task automatic prep_pixels(input int n);
      logic [15:0] p;
      pix_q.delete();
      pix_ref.delete();
      for (int i = 0; i < n; i++) begin
         p = 16'($urandom);
         pix_q.push_back(p);
         pix_ref.push_back(p);
      end
   endtask

   task automatic run_tile(input int gh, gw, gc, gth, gtw, gho, gwo,
                           input int pv, pr, max_cyc);
      bit prev_stall, forced;
      logic [31:0] hold_a;
      logic [15:0] hold_d;
      int stall_left;
      obs_addr.delete();
      obs_data.delete();
      done_cnt = 0; done_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
      busy_hi = 0; wr_seen = 0; bp_viol = 0; extra_done = 0; extra_rdy = 0;
      stall_cnt = 0; bp_addr = '1; timed_out = 1'b1;
      prev_stall = 1'b0; hold_a = '0; hold_d = '0; stall_left = stall_len;
      @(negedge clk);
      H = 16'(gh); W = 16'(gw); C = 16'(gc); Th = 16'(gth); Tw = 16'(gtw);
      ho = 16'(gho); wo = 16'(gwo); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      H = 16'($urandom); W = 16'($urandom); C = 16'($urandom);
      Th = 16'($urandom); Tw = 16'($urandom); ho = 16'($urandom); wo = 16'($urandom);
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         if (busy) busy_hi++;
         if (done) begin
            done_cnt++; done_cyc = cyc; timed_out = 1'b0;
            break;
         end
         if (prev_stall && (wr_addr !== hold_a || wr_data !== hold_d)) bp_viol++;
         in_valid = (pix_q.size() > 0) && ($urandom_range(0, 99) < pv);
         in_data  = in_valid ? pix_q[0] : 16'($urandom);
         forced = wr_en && (obs_addr.size() == stall_at) && (stall_left > 0);
         if (forced) begin
            wr_ready = 1'b0; stall_left--; stall_cnt++; bp_addr = wr_addr;
         end else begin
            wr_ready = ($urandom_range(0, 99) < pr);
         end
         #1;
         prev_stall = wr_en && !wr_ready;
         hold_a = wr_addr; hold_d = wr_data;
         if (prev_stall && in_ready) bp_viol++;
         if (in_valid && in_ready) void'(pix_q.pop_front());
         if (wr_en) wr_seen++;
         if (wr_en && wr_ready) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) extra_done++;
         if (in_ready) extra_rdy++;
      end
      stall_at = -1; stall_len = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; in_data = '0;
      H = '0; W = '0; C = '0; Th = '0; Tw = '0; ho = '0; wo = '0;
      stall_at = -1; stall_len = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp_n++; if ({in_ready, wr_en, busy, done} !== 4'b0000) begin
         err_n++; $display("FAIL reset_ctrl: got %b want 0000", {in_ready, wr_en, busy, done}); end
      cmp_n++; if (wr_addr !== 32'd0 || wr_data !== 16'd0) begin
         err_n++; $display("FAIL reset_wr: addr %0d data %h want 0/0", wr_addr, wr_data); end
      cmp_n++; if (beat_cnt !== 32'd0) begin
         err_n++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      model_tile(4, 4, 2, 2, 2, 0, 0);
      prep_pixels(exp_addr.size());
      run_tile(4, 4, 2, 2, 2, 0, 0, 100, 100, 200);
      cmp_n++; if (timed_out || obs_addr.size() != exp_addr.size()) begin
         err_n++; $display("FAIL basic_count: got %0d writes timeout=%0d want %0d", obs_addr.size(), timed_out, exp_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         cmp_n++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== relu_ref(pix_ref[i])) begin
            err_n++; $display("FAIL basic_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], relu_ref(pix_ref[i])); end
      end
      cmp_n++; if (first_acc_cyc != 1 || last_acc_cyc != 8) begin
         err_n++; $display("FAIL basic_b2b: accepts cycles %0d..%0d want 1..8", first_acc_cyc, last_acc_cyc); end
      cmp_n++; if (done_cnt + extra_done != 1 || done_cyc != last_acc_cyc + 1) begin
         err_n++; $display("FAIL basic_done: pulses %0d at %0d want 1 at %0d", done_cnt + extra_done, done_cyc, last_acc_cyc + 1); end
      cmp_n++; if (beat_cnt !== 32'd8) begin
         err_n++; $display("FAIL basic_beat_cnt: got %0d want 8", beat_cnt); end
   endtask

   task automatic test_edge_clamp;
      model_tile(4, 4, 1, 3, 3, 2, 2);
      prep_pixels(exp_addr.size());
      run_tile(4, 4, 1, 3, 3, 2, 2, 100, 100, 200);
      cmp_n++; if (timed_out || obs_addr.size() != 4 || exp_addr.size() != 4) begin
         err_n++; $display("FAIL clamp_count: got %0d writes timeout=%0d want 4", obs_addr.size(), timed_out); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         cmp_n++; if (obs_addr[i] !== exp_addr[i]) begin
            err_n++; $display("FAIL clamp_addr[%0d]: got %0d want %0d", i, obs_addr[i], exp_addr[i]); end
      end
      cmp_n++; if (beat_cnt !== 32'd4 || extra_rdy != 0) begin
         err_n++; $display("FAIL clamp_tail: beat_cnt %0d in_ready_after %0d want 4/0", beat_cnt, extra_rdy); end
   endtask

   task automatic test_backpressure;
      model_tile(4, 4, 2, 2, 2, 0, 0);
      prep_pixels(exp_addr.size());
      stall_at = 2; stall_len = 3;
      run_tile(4, 4, 2, 2, 2, 0, 0, 100, 100, 200);
      cmp_n++; if (stall_cnt != 3 || bp_addr !== 32'd2) begin
         err_n++; $display("FAIL bp_stall: stalls %0d at addr %0d want 3 at 2", stall_cnt, bp_addr); end
      cmp_n++; if (bp_viol != 0) begin
         err_n++; $display("FAIL bp_hold: violations %0d want 0", bp_viol); end
      cmp_n++; if (timed_out || obs_addr.size() != exp_addr.size()) begin
         err_n++; $display("FAIL bp_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         cmp_n++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== relu_ref(pix_ref[i])) begin
            err_n++; $display("FAIL bp_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], relu_ref(pix_ref[i])); end
      end
      cmp_n++; if (beat_cnt !== 32'd8) begin
         err_n++; $display("FAIL bp_beat_cnt: got %0d want 8", beat_cnt); end
   endtask

   task automatic test_degenerate;
      for (int r = 0; r < 2; r++) begin
         prep_pixels(0);
         if (r == 0) run_tile(4, 4, 0, 2, 2, 0, 0, 100, 100, 20);
         else        run_tile(4, 4, 2, 2, 2, 0, 4, 100, 100, 20);
         cmp_n++; if (done_cyc != 0 || done_cnt + extra_done != 1) begin
            err_n++; $display("FAIL degen%0d_done: at %0d pulses %0d want at 0 once", r, done_cyc, done_cnt + extra_done); end
         cmp_n++; if (wr_seen != 0 || busy_hi != 0 || beat_cnt !== 32'd0) begin
            err_n++; $display("FAIL degen%0d_quiet: wr %0d busy %0d beats %0d want 0", r, wr_seen, busy_hi, beat_cnt); end
      end
   endtask

   task automatic test_reset_mid_tile;
      int acc = 0;
      int nd  = 0;
      @(negedge clk);
      H = 16'd4; W = 16'd4; C = 16'd2; Th = 16'd2; Tw = 16'd2; ho = '0; wo = '0;
      start = 1'b1; in_valid = 1'b1; wr_ready = 1'b1; in_data = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20 && acc < 3; k++) begin
         if (wr_en && wr_ready) acc++;
         @(posedge clk);
         @(negedge clk);
      end
      cmp_n++; if (acc != 3 || beat_cnt !== 32'd3) begin
         err_n++; $display("FAIL rstmid_pre: accepts %0d beat_cnt %0d want 3", acc, beat_cnt); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      cmp_n++; if (wr_en !== 1'b0 || busy !== 1'b0 || beat_cnt !== 32'd0 || done !== 1'b0) begin
         err_n++; $display("FAIL rstmid_post: wr_en %b busy %b beat_cnt %0d done %b want 0", wr_en, busy, beat_cnt, done); end
      for (int k = 0; k < 4; k++) begin
         if (done || in_ready) nd++;
         @(negedge clk);
      end
      cmp_n++; if (nd != 0) begin
         err_n++; $display("FAIL rstmid_idle: done/in_ready cycles %0d want 0", nd); end
      model_tile(4, 4, 2, 2, 2, 0, 0);
      prep_pixels(exp_addr.size());
      run_tile(4, 4, 2, 2, 2, 0, 0, 100, 100, 200);
      cmp_n++; if (obs_addr.size() != 8 || obs_addr[0] !== 32'd0 || beat_cnt !== 32'd8) begin
         err_n++; $display("FAIL rstmid_restart: writes %0d beat_cnt %0d want 8 from addr 0", obs_addr.size(), beat_cnt); end
   endtask

   task automatic test_feature;
      model_tile(1, 1, 2, 1, 1, 0, 0);
      prep_pixels(0);
      pix_q.push_back(16'hFFF6);
      pix_q.push_back(16'h0005);
      run_tile(1, 1, 2, 1, 1, 0, 0, 100, 100, 50);
      cmp_n++; if (obs_data.size() != 2) begin
         err_n++; $display("FAIL feat_count: got %0d want 2", obs_data.size());
      end else begin
`ifdef OUT_RELU_EN
         if (obs_data[0] !== 16'h0000) begin
            err_n++; $display("FAIL feat_neg: got %h want 0000", obs_data[0]); end
`else
         if (obs_data[0] !== 16'hFFF6) begin
            err_n++; $display("FAIL feat_neg: got %h want fff6", obs_data[0]); end
`endif
         cmp_n++; if (obs_data[1] !== 16'h0005) begin
            err_n++; $display("FAIL feat_pos: got %h want 0005", obs_data[1]); end
      end
   endtask

   task automatic test_random;
      int gh, gw, gc, gth, gtw, gho, gwo, n;
      for (int it = 0; it < 25; it++) begin
         gh = $urandom_range(1, 6); gw = $urandom_range(1, 6); gc = $urandom_range(0, 3);
         gth = $urandom_range(0, 4); gtw = $urandom_range(0, 4);
         gho = $urandom_range(0, gh); gwo = $urandom_range(0, gw);
         model_tile(gh, gw, gc, gth, gtw, gho, gwo);
         n = exp_addr.size();
         prep_pixels(n);
         run_tile(gh, gw, gc, gth, gtw, gho, gwo, $urandom_range(30, 100), $urandom_range(30, 100), 3000);
         cmp_n++; if (timed_out || obs_addr.size() != n || beat_cnt !== 32'(n)) begin
            err_n++; $display("FAIL rnd%0d_count: writes %0d beat_cnt %0d timeout %0d want %0d", it, obs_addr.size(), beat_cnt, timed_out, n); end
         for (int i = 0; i < obs_addr.size() && i < n; i++) begin
            cmp_n++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== relu_ref(pix_ref[i])) begin
               err_n++; $display("FAIL rnd%0d_write[%0d]: got %0d/%h want %0d/%h", it, i, obs_addr[i], obs_data[i], exp_addr[i], relu_ref(pix_ref[i])); end
         end
         cmp_n++; if (done_cnt + extra_done != 1 || done_cyc != ((n == 0) ? 0 : last_acc_cyc + 1)) begin
            err_n++; $display("FAIL rnd%0d_done: pulses %0d at %0d last accept %0d", it, done_cnt + extra_done, done_cyc, last_acc_cyc); end
         cmp_n++; if (bp_viol != 0 || extra_rdy != 0) begin
            err_n++; $display("FAIL rnd%0d_hold: violations %0d in_ready_after %0d want 0/0", it, bp_viol, extra_rdy); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edge_clamp();
      test_backpressure();
      test_degenerate();
      test_reset_mid_tile();
      test_feature();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
